// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: first-quadrant (x, y) in Q1.16 -> atan2 angle (Q1.16) and
// K-compensated magnitude (Q2.16), one micro-rotation per clock, valid/ready on both sides.
module cordic_vector #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] x_in,
  input  logic [16:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] theta_out,
  output logic [17:0] mag_out
);
  localparam logic [15:0] K_GAIN  = 16'h9B75;
  localparam logic [17:0] HALF_PI = 18'h1921F;

  typedef enum logic [1:0] {IDLE, RUN, SCALE, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [35:0] x_q, x_d, y_q, y_d;
  logic signed [18:0] z_q, z_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic [16:0]        theta_q, theta_d;
  logic [17:0]        mag_q, mag_d;

  logic [16:0]        atan_i;
  logic signed [18:0] atan_ext;
  logic [35:0]        prod;
  logic [19:0]        prod_q216;

  function automatic logic [16:0] atan_lookup(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lookup = 17'h0C910;
      5'd1:    atan_lookup = 17'h076B2;
      5'd2:    atan_lookup = 17'h03EB7;
      5'd3:    atan_lookup = 17'h01FD6;
      5'd4:    atan_lookup = 17'h00FFB;
      5'd5:    atan_lookup = 17'h007FF;
      5'd6:    atan_lookup = 17'h00400;
      5'd7:    atan_lookup = 17'h00200;
      5'd8:    atan_lookup = 17'h00100;
      5'd9:    atan_lookup = 17'h00080;
      5'd10:   atan_lookup = 17'h00040;
      5'd11:   atan_lookup = 17'h00020;
      5'd12:   atan_lookup = 17'h00010;
      5'd13:   atan_lookup = 17'h00008;
      5'd14:   atan_lookup = 17'h00004;
      5'd15:   atan_lookup = 17'h00002;
      5'd16:   atan_lookup = 17'h00001;
      default: atan_lookup = 17'h00000;
    endcase
  endfunction

  assign atan_i    = atan_lookup(cnt_q);
  assign atan_ext  = signed'({2'b00, atan_i});
  // x stays positive for first-quadrant inputs, so its Q3.16 slice is treated as unsigned.
  assign prod      = x_q[35:16] * K_GAIN;
  assign prod_q216 = 20'(prod >> 16);

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign theta_out = theta_q;
  assign mag_out   = mag_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    theta_d = theta_q;
    mag_d   = mag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = signed'({3'b000, x_in, 16'h0000});
          y_d     = signed'({3'b000, y_in, 16'h0000});
          z_d     = '0;
          cnt_d   = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          state_d = RUN;
        end
      end
      RUN: begin
        // Simultaneous update: both right-hand sides read the pre-update x_q/y_q.
        if (!y_q[35]) begin
          x_d = x_q + (y_q >>> cnt_q);
          y_d = y_q - (x_q >>> cnt_q);
          z_d = z_q + atan_ext;
        end else begin
          x_d = x_q - (y_q >>> cnt_q);
          y_d = y_q + (x_q >>> cnt_q);
          z_d = z_q - atan_ext;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) begin
          state_d = SCALE;
        end
      end
      SCALE: begin
        if (x_q[35]) begin
          mag_d = '0;
        end else if (prod_q216[19:18] != 2'b00) begin
          mag_d = 18'h3FFFF;
        end else begin
          mag_d = prod_q216[17:0];
        end
        if (z_q[18]) begin
          theta_d = '0;
        end else if (z_q[17:0] > HALF_PI) begin
          theta_d = HALF_PI[16:0];
        end else begin
          theta_d = z_q[16:0];
        end
        if (zero_q) begin
          theta_d = '0;
          mag_d   = '0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      theta_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      theta_q <= theta_d;
      mag_q   <= mag_d;
    end
  end
endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector: floating-point atan2/magnitude model with a per-cycle
// compare process, plus directed vectors with hand-computed literal expectations.
module tb_cordic_vector;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] x_in;
  logic [16:0] y_in;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] theta_out;
  logic [17:0] mag_out;

  cordic_vector #(.ITER(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .theta_out(theta_out), .mag_out(mag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int tol_mag;
    int acc_cyc;
  } item_t;

  item_t       q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          results = 0;
  int          cur_tol = 4;
  bit          chk_en = 0;
  bit          seen = 0;
  bit          was_empty;
  logic [16:0] hold_theta;
  logic [17:0] hold_mag;
  logic [16:0] last_theta = '0;
  logic [17:0] last_mag = '0;

  // Model and compare process: evaluated on every falling edge.
  always @(negedge clk) begin
    real mt, mm, dt, dm;
    item_t it;
    cyc = cyc + 1;
    if (chk_en) begin
      was_empty = (q.size() == 0);
      checks++;
      if (in_ready !== (was_empty && !rst)) begin
        failures++;
        $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready, was_empty && !rst);
      end
      if (out_valid === 1'b1) begin
        if (was_empty) begin
          checks++; failures++;
          $display("FAIL spurious_out cyc=%0d got out_valid=1 want 0 (no pending op)", cyc);
        end else begin
          it = q[0];
          mt = $atan2(real'(it.y), real'(it.x)) * 65536.0;
          mm = $sqrt(real'(it.x) * real'(it.x) + real'(it.y) * real'(it.y));
          if (!seen) begin
            seen = 1;
            hold_theta = theta_out;
            hold_mag = mag_out;
            checks++;
            if (cyc - it.acc_cyc != 18) begin
              failures++;
              $display("FAIL latency got=%0d want=18", cyc - it.acc_cyc);
            end
          end else begin
            checks++;
            if (theta_out !== hold_theta || mag_out !== hold_mag) begin
              failures++;
              $display("FAIL hold_stable got=%h/%h want=%h/%h", theta_out, mag_out, hold_theta, hold_mag);
            end
          end
          dt = real'(theta_out) - mt;
          if (dt < 0.0) dt = -dt;
          dm = real'(mag_out) - mm;
          if (dm < 0.0) dm = -dm;
          checks++;
          if (dt > 4.0) begin
            failures++;
            $display("FAIL theta x=%h y=%h got=%h want=%0.2f", it.x, it.y, theta_out, mt);
          end
          checks++;
          if (dm > real'(it.tol_mag)) begin
            failures++;
            $display("FAIL mag x=%h y=%h got=%h want=%0.2f", it.x, it.y, mag_out, mm);
          end
          if (out_ready === 1'b1) begin
            last_theta = theta_out;
            last_mag = mag_out;
            results++;
            seen = 0;
            void'(q.pop_front());
          end
        end
      end
      if (rst) begin
        q.delete();
        seen = 0;
      end else if (in_valid && was_empty) begin
        it.x = int'(x_in);
        it.y = int'(y_in);
        it.tol_mag = cur_tol;
        it.acc_cyc = cyc;
        q.push_back(it);
      end
    end
  end

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s got=%h want=%h..%h", name, got, lo, hi);
    end
  endtask

  task automatic send(input logic [16:0] x, input logic [16:0] y, input int tol);
    bit got = 0;
    cur_tol = tol;
    in_valid = 1'b1;
    x_in = x;
    y_in = y;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept_timeout got=no accept want=accept x=%h y=%h", x, y);
    end
    in_valid = 1'b0;
    x_in = 17'($urandom);
    y_in = 17'($urandom);
  endtask

  task automatic wait_result();
    int n0 = results;
    for (int k = 0; k < 60 && results == n0; k++) @(posedge clk);
    #1;
    if (results == n0) begin
      checks++; failures++;
      $display("FAIL result_timeout got=no result want=result");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    logic [16:0] th0;
    logic [17:0] m0;
    rst = 1'b1;
    in_valid = 1'b1;
    x_in = 17'h10000;
    y_in = 17'h08000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk_range("rst_in_ready", int'(in_ready), 1, 1);
    chk_range("rst_out_valid", int'(out_valid), 0, 0);
    chk_range("rst_theta", int'(theta_out), 0, 0);
    chk_range("rst_mag", int'(mag_out), 0, 0);
    @(posedge clk); #1;

    send(17'h10000, 17'h00000, 4); wait_result();
    chk_range("x1y0_theta", int'(last_theta), 'h00000, 'h00004);
    chk_range("x1y0_mag", int'(last_mag), 'h0FFFC, 'h10004);

    send(17'h10000, 17'h10000, 4); wait_result();
    chk_range("x1y1_theta", int'(last_theta), 'h0C90C, 'h0C914);
    chk_range("x1y1_mag", int'(last_mag), 'h16A06, 'h16A0E);

    send(17'h00000, 17'h10000, 4); wait_result();
    chk_range("x0y1_theta", int'(last_theta), 'h1921B, 'h1921F);
    chk_range("x0y1_mag", int'(last_mag), 'h0FFFC, 'h10004);

    send(17'h1FFFF, 17'h1FFFF, 8); wait_result();
    chk_range("max_theta", int'(last_theta), 'h0C90C, 'h0C914);
    chk_range("max_mag", int'(last_mag), 'h2D40B, 'h2D41B);

    send(17'h00000, 17'h00000, 4); wait_result();
    chk_range("zero_theta", int'(last_theta), 0, 0);
    chk_range("zero_mag", int'(last_mag), 0, 0);

    // Backpressure: result held for 10 cycles while new inputs are offered.
    out_ready = 1'b0;
    send(17'h0DDB4, 17'h08000, 4);
    for (int k = 0; k < 40 && out_valid !== 1'b1; k++) @(negedge clk);
    chk_range("bp_valid", int'(out_valid), 1, 1);
    th0 = theta_out;
    m0 = mag_out;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      x_in = 17'h01234;
      y_in = 17'h04321;
      @(negedge clk);
      chk_range("bp_theta", int'(theta_out), int'(th0), int'(th0));
      chk_range("bp_mag", int'(mag_out), int'(m0), int'(m0));
      chk_range("bp_in_ready", int'(in_ready), 0, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_range("bp_release_in_ready", int'(in_ready), 1, 1);
    chk_range("bp_theta_lit", int'(last_theta), 'h08606, 'h0860E);
    @(posedge clk); #1;

    // Reset abort at accept+5, then resubmit 30 degrees.
    n_before = results;
    send(17'h12345, 17'h05678, 4);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_range("abort_out_valid", int'(out_valid), 0, 0);
    chk_range("abort_theta", int'(theta_out), 0, 0);
    chk_range("abort_mag", int'(mag_out), 0, 0);
    @(posedge clk); #1;
    send(17'h0DDB4, 17'h08000, 4); wait_result();
    chk_range("abort_result_count", results - n_before, 1, 1);
    chk_range("deg30_theta", int'(last_theta), 'h08606, 'h0860E);
    chk_range("deg30_mag", int'(last_mag), 'h0FFFC, 'h10004);

    for (int n = 0; n < 1000; n++) begin
      send(17'($urandom), 17'($urandom), 4);
      wait_result();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
